// File: rtl/mult_plus_sequencer_if.sv
// Bus between the MULTPLUS sequencer and its environment: request, operands,
// shared-ALU control/return path and the stall/done/result status.
interface mult_plus_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] operand_c;
    logic [WIDTH-1:0] alu_result;
    logic             alu_grant;
    logic [3:0]       alu_operation;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, operand_a, operand_b, operand_c, alu_result,
        input  alu_grant, alu_operation, alu_a, alu_b, stall, done, result
    );

    modport slave (
        input  start, operand_a, operand_b, operand_c, alu_result,
        output alu_grant, alu_operation, alu_a, alu_b, stall, done, result
    );
endinterface

// File: rtl/mult_plus_sequencer.sv
// MULTPLUS sequencer: result = A*B + C via shift-add passes on the shared ALU.
// Optional feature macro: MULT_EARLY_EXIT_EN (leave MUL once the multiplier is exhausted).
module mult_plus_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    mult_plus_sequencer_if.slave   bus
);
    localparam int         CNT_W  = $clog2(WIDTH) + 1;
    localparam logic [3:0] OP_NOP = 4'b1001;
    localparam logic [3:0] OP_ADD = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ADDC = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] c_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             mul_last_s;

`ifdef MULT_EARLY_EXIT_EN
    // Remaining multiplier bits all zero after this pass: nothing more to add.
    assign mul_last_s = (cnt_q == CNT_W'(WIDTH - 1)) || (q_q[WIDTH-1:1] == '0);
`else
    assign mul_last_s = (cnt_q == CNT_W'(WIDTH - 1));
`endif

    // Sequencer state and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            p_q      <= '0;
            m_q      <= '0;
            q_q      <= '0;
            c_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        p_q     <= '0;
                        m_q     <= bus.operand_a;
                        q_q     <= bus.operand_b;
                        c_q     <= bus.operand_c;
                        cnt_q   <= '0;
                        state_q <= ST_MUL;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    p_q   <= bus.alu_result;
                    m_q   <= m_q << 1;
                    q_q   <= q_q >> 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (mul_last_s) begin
                        state_q <= ST_ADDC;
                    end else begin
                        state_q <= ST_MUL;
                    end
                end
                ST_ADDC: begin
                    result_q <= bus.alu_result;
                    state_q  <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ALU ownership and status decoded from state and registered operands
    always_comb begin
        bus.alu_grant     = 1'b0;
        bus.alu_operation = OP_NOP;
        bus.alu_a         = '0;
        bus.alu_b         = '0;
        bus.stall         = 1'b0;
        bus.done          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.stall = bus.start;
            end
            ST_MUL: begin
                bus.alu_grant     = 1'b1;
                bus.alu_operation = OP_ADD;
                bus.alu_a         = p_q;
                bus.alu_b         = q_q[0] ? m_q : '0;
                bus.stall         = 1'b1;
            end
            ST_ADDC: begin
                bus.alu_grant     = 1'b1;
                bus.alu_operation = OP_ADD;
                bus.alu_a         = p_q;
                bus.alu_b         = c_q;
                bus.stall         = 1'b1;
            end
            ST_DONE: begin
                bus.done = 1'b1;
            end
            default: begin
                bus.stall = 1'b0;
            end
        endcase
    end

    assign bus.result = result_q;
endmodule
